// File: rtl/x_clkdiv_multi.sv
// Multi-channel clock divider producing per-channel enable pulses and divided levels,
// gated by a shared acquire/lock state machine.
module x_clkdiv_multi #(
    parameter int unsigned NUM_CH                = 4,
    parameter int unsigned CNT_W                 = 8,
    parameter int unsigned LOCK_CYCLES           = 16,
    parameter string       DUTY_CYCLE_CORRECTION = "TRUE"
) (
    input  logic                      CLKIN,
    input  logic                      RST,
    input  logic [NUM_CH*CNT_W-1:0]   DIV,
    input  logic [NUM_CH*CNT_W-1:0]   PHASE,
    input  logic                      CFG_LOAD,
    output logic [NUM_CH-1:0]         CLKEN,
    output logic [NUM_CH-1:0]         CLKDV,
    output logic                      LOCKED
);

    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned REL_W  = CNT_W + 1;
    localparam bit          DCC_ON = (DUTY_CYCLE_CORRECTION == "TRUE");

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic [LOCK_W-1:0] w_lock_cnt_nxt;
    logic              r_locked;
    logic              w_locked_nxt;
    logic              w_lock_done;

    // Last acquire cycle: the increment on this edge reaches LOCK_CYCLES.
    assign w_lock_done = (r_lock_cnt >= LOCK_W'(LOCK_CYCLES - 1));

    always_ff @(posedge CLKIN) begin
        if (RST) begin
            r_state    <= ST_RESET;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_locked   <= w_locked_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            ST_RESET, ST_ACQUIRE: begin
                if (CFG_LOAD) begin
                    w_state_nxt    = ST_ACQUIRE;
                    w_lock_cnt_nxt = '0;
                end else begin
                    w_state_nxt    = w_lock_done ? ST_LOCKED : ST_ACQUIRE;
                    w_lock_cnt_nxt = r_lock_cnt + LOCK_W'(1);
                end
            end
            ST_LOCKED: begin
                if (CFG_LOAD) begin
                    w_state_nxt    = ST_ACQUIRE;
                    w_lock_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = ST_RESET;
                w_lock_cnt_nxt = '0;
            end
        endcase
        w_locked_nxt = (w_state_nxt == ST_LOCKED);
    end

    assign LOCKED = r_locked;

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        logic [CNT_W-1:0] w_div_in;
        logic [CNT_W-1:0] w_ph_in;
        logic [CNT_W-1:0] w_d;
        logic [CNT_W-1:0] w_p;
        logic [CNT_W-1:0] r_div;
        logic [CNT_W-1:0] r_phase;
        logic [CNT_W-1:0] r_cnt;
        logic [REL_W-1:0] w_rel;
        logic [REL_W-1:0] w_hi;

        assign w_div_in = DIV[g*CNT_W +: CNT_W];
        assign w_ph_in  = PHASE[g*CNT_W +: CNT_W];
        // Sanitise at capture so the datapath only ever sees D>=1 and P<D.
        assign w_d = (w_div_in == '0) ? CNT_W'(1) : w_div_in;
        assign w_p = (w_ph_in >= w_d) ? (w_d - CNT_W'(1)) : w_ph_in;

        always_ff @(posedge CLKIN) begin
            if (RST || CFG_LOAD) begin
                r_div   <= w_d;
                r_phase <= w_p;
                r_cnt   <= '0;
            end else if (r_cnt >= (r_div - CNT_W'(1))) begin
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end

        assign w_rel = (r_cnt >= r_phase)
                     ? (REL_W'(r_cnt) - REL_W'(r_phase))
                     : (REL_W'(r_cnt) + REL_W'(r_div) - REL_W'(r_phase));
        assign w_hi  = DCC_ON ? ((REL_W'(r_div) + REL_W'(1)) >> 1) : REL_W'(1);

        assign CLKEN[g] = r_locked & (r_cnt == r_phase);
        assign CLKDV[g] = r_locked & (w_rel < w_hi);
    end

endmodule
